// File: rtl/can_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_timing_pkg
// Brief    : Segment encoding and default timing constants for CAN bit timing.
// Revision : 1.0 - initial release
// ============================================================================
package can_timing_pkg;

    localparam logic [1:0] c_seg_sync = 2'd0;
    localparam logic [1:0] c_seg_prop = 2'd1;
    localparam logic [1:0] c_seg_ph1  = 2'd2;
    localparam logic [1:0] c_seg_ph2  = 2'd3;

    // 20 MHz clk / 4 = 5 MHz tq; 1+3+3+3 = 10 tq per bit
    localparam logic [9:0] c_def_tq_div   = 10'd4;
    localparam logic [3:0] c_def_prop_seg = 4'd3;
    localparam logic [3:0] c_def_phase1   = 4'd3;
    localparam logic [3:0] c_def_phase2   = 4'd3;
    localparam logic [2:0] c_def_sjw      = 3'd1;

endpackage
`default_nettype wire

// File: rtl/can_tq_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : can_tq_prescaler
// Brief    : Time-quantum prescaler; ticks on the last clk of each tq.
// Revision : 1.0 - initial release
// ============================================================================
module can_tq_prescaler #(
    parameter logic [9:0] TQ_DIV = 10'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tq_tick
);

    logic [9:0] r_presc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_presc <= '0;
        end else if (r_presc == TQ_DIV - 10'd1) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 10'd1;
        end
    end

    assign tq_tick = (r_presc == TQ_DIV - 10'd1);

endmodule
`default_nettype wire

// File: rtl/can_bit_timing.sv
`default_nettype none
// ============================================================================
// Module   : can_bit_timing
// Brief    : CAN tq sequencer (SYNC/PROP/PH1/PH2) with hard sync and resync.
// Revision : 1.0 - initial release
// ============================================================================
module can_bit_timing
    import can_timing_pkg::*;
#(
    parameter logic [9:0] TQ_DIV   = c_def_tq_div,
    parameter logic [3:0] PROP_SEG = c_def_prop_seg,
    parameter logic [3:0] PHASE1   = c_def_phase1,
    parameter logic [3:0] PHASE2   = c_def_phase2,
    parameter logic [2:0] SJW      = c_def_sjw
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rx,
    input  logic       hard_sync_en,
    output logic       tq_tick,
    output logic       tx_pulse,
    output logic       sample_pulse,
    output logic       sampled_bit,
    output logic [1:0] seg
);

    logic [1:0] r_seg;
    logic [3:0] r_seg_cnt;
    logic [2:0] r_ph1_ext;
    logic [2:0] r_ph2_short;
    logic       r_resync_done;
    logic       r_rx_prev;
    logic       r_sampled_bit;
    logic       r_bit_start;

    logic       w_active;
    logic       w_presc_tick;
    logic       w_tick;
    logic       w_fall;
    logic       w_hard;
    logic       w_resync;
    logic       w_jump;
    logic       w_seg_last;
    logic       w_sample;
    logic [4:0] w_ph1_len;
    logic [4:0] w_ph2_len;
    logic [4:0] w_late_e;
    logic [2:0] w_late_ext;
    logic [4:0] w_early_r;

    logic [1:0] w_next_seg;
    logic [3:0] w_next_cnt;
    logic [2:0] w_next_ext;
    logic [2:0] w_next_short;
    logic       w_next_done;

    assign w_active = enable & ~rst;

    can_tq_prescaler #(
        .TQ_DIV (TQ_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (~enable | w_jump),
        .tq_tick (w_presc_tick)
    );

    assign w_tick    = w_presc_tick & w_active;
    assign w_fall    = r_rx_prev & ~rx;
    assign w_hard    = w_fall & hard_sync_en;
    assign w_resync  = w_fall & ~hard_sync_en & ~r_resync_done & r_sampled_bit;
    assign w_ph1_len = {1'b0, PHASE1} + {2'b00, r_ph1_ext};
    assign w_ph2_len = {1'b0, PHASE2} - {2'b00, r_ph2_short};

    // Late edge: error counts tq elapsed since the end of SYNC
    assign w_late_e   = (r_seg == c_seg_prop) ? ({1'b0, r_seg_cnt} + 5'd1)
                                              : ({1'b0, PROP_SEG} + {1'b0, r_seg_cnt} + 5'd1);
    assign w_late_ext = (w_late_e > {2'b00, SJW}) ? SJW : w_late_e[2:0];
    assign w_early_r  = {1'b0, PHASE2} - {1'b0, r_seg_cnt};

    // Early edge close enough to the bit end: the edge tq itself becomes SYNC
    assign w_jump = w_hard |
                    (w_resync & (r_seg == c_seg_ph2) & (w_early_r <= {2'b00, SJW}));

    always_comb begin
        w_seg_last = 1'b0;
        case (r_seg)
            c_seg_sync: w_seg_last = 1'b1;
            c_seg_prop: w_seg_last = (r_seg_cnt == PROP_SEG - 4'd1);
            c_seg_ph1:  w_seg_last = ({1'b0, r_seg_cnt} == w_ph1_len - 5'd1);
            default:    w_seg_last = ({1'b0, r_seg_cnt} == w_ph2_len - 5'd1);
        endcase
    end

    assign w_sample = w_tick & (r_seg == c_seg_ph1) & w_seg_last;

    always_comb begin
        w_next_seg   = r_seg;
        w_next_cnt   = r_seg_cnt;
        w_next_ext   = r_ph1_ext;
        w_next_short = r_ph2_short;
        w_next_done  = r_resync_done;

        if (w_tick) begin
            if (w_seg_last) begin
                w_next_cnt = '0;
                case (r_seg)
                    c_seg_sync: w_next_seg = c_seg_prop;
                    c_seg_prop: w_next_seg = c_seg_ph1;
                    c_seg_ph1:  w_next_seg = c_seg_ph2;
                    default: begin
                        w_next_seg   = c_seg_sync;
                        w_next_ext   = '0;
                        w_next_short = '0;
                    end
                endcase
            end else begin
                w_next_cnt = r_seg_cnt + 4'd1;
            end
        end

        if (w_sample) begin
            w_next_done = 1'b0;
        end

        // Edge actions override the tick advance and the sample-point clear
        if (w_jump) begin
            w_next_seg   = c_seg_prop;
            w_next_cnt   = '0;
            w_next_ext   = '0;
            w_next_short = '0;
            w_next_done  = 1'b1;
        end else if (w_resync) begin
            w_next_done = 1'b1;
            case (r_seg)
                c_seg_prop, c_seg_ph1: w_next_ext   = w_late_ext;
                c_seg_ph2:             w_next_short = SJW;
                default:               ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_seg         <= c_seg_sync;
            r_seg_cnt     <= '0;
            r_ph1_ext     <= '0;
            r_ph2_short   <= '0;
            r_resync_done <= 1'b0;
            r_rx_prev     <= 1'b1;
            r_sampled_bit <= 1'b1;
            r_bit_start   <= 1'b1;
        end else begin
            r_seg         <= w_next_seg;
            r_seg_cnt     <= w_next_cnt;
            r_ph1_ext     <= w_next_ext;
            r_ph2_short   <= w_next_short;
            r_resync_done <= w_next_done;
            r_rx_prev     <= rx;
            r_bit_start   <= (w_next_seg == c_seg_sync) && (r_seg != c_seg_sync);
            if (w_sample) begin
                r_sampled_bit <= rx;
            end
        end
    end

    assign tq_tick      = w_tick;
    assign tx_pulse     = w_active & r_bit_start;
    assign sample_pulse = w_sample;
    assign sampled_bit  = r_sampled_bit;
    assign seg          = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_can_bit_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_bit_timing
// Brief    : Self-checking bench: position-in-bit reference model plus
//            directed timing scenarios with hand-computed distances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_bit_timing;

    localparam int TQ    = 4;
    localparam int PROPS = 3;
    localparam int P1    = 3;
    localparam int P2    = 3;
    localparam int SJW   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rx = 1'b1;
    logic       hard_sync_en = 1'b0;
    logic       tq_tick;
    logic       tx_pulse;
    logic       sample_pulse;
    logic       sampled_bit;
    logic [1:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    can_bit_timing dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx           (rx),
        .hard_sync_en (hard_sync_en),
        .tq_tick      (tq_tick),
        .tx_pulse     (tx_pulse),
        .sample_pulse (sample_pulse),
        .sampled_bit  (sampled_bit),
        .seg          (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bit is a clk position from the bit's first clk
    int m_pos   = 0;
    int m_ext   = 0;
    int m_short = 0;
    bit m_done  = 1'b0;
    bit m_rxp   = 1'b1;
    bit m_sb    = 1'b1;

    always @(negedge clk) begin : model
        int  ph1_end, bit_end, eseg, n_pos, n_ext, n_short, k, e;
        bit  act, etick, etx, esmp, fall, n_done, n_sb;

        act     = !rst && enable;
        ph1_end = TQ * (1 + PROPS + P1 + m_ext);
        bit_end = ph1_end + TQ * (P2 - m_short);
        if (m_pos < TQ)                    eseg = 0;
        else if (m_pos < TQ * (1 + PROPS)) eseg = 1;
        else if (m_pos < ph1_end)          eseg = 2;
        else                               eseg = 3;
        etick = act && (m_pos % TQ == TQ - 1);
        etx   = act && (m_pos == 0);
        esmp  = act && (m_pos == ph1_end - 1);

        check("seg",          seg,          eseg);
        check("tq_tick",      tq_tick,      etick);
        check("tx_pulse",     tx_pulse,     etx);
        check("sample_pulse", sample_pulse, esmp);
        check("sampled_bit",  sampled_bit,  m_sb);

        if (!act) begin
            m_pos = 0; m_ext = 0; m_short = 0; m_done = 0; m_rxp = 1; m_sb = 1;
        end else begin
            fall    = m_rxp && !rx;
            n_pos   = (m_pos == bit_end - 1) ? 0 : m_pos + 1;
            n_ext   = (n_pos == 0) ? 0 : m_ext;
            n_short = (n_pos == 0) ? 0 : m_short;
            n_done  = m_done;
            n_sb    = m_sb;
            if (esmp) begin
                n_sb   = rx;
                n_done = 0;
            end
            if (fall && hard_sync_en) begin
                n_pos = TQ; n_ext = 0; n_short = 0; n_done = 1;
            end else if (fall && !m_done && m_sb) begin
                n_done = 1;
                if (eseg == 1 || eseg == 2) begin
                    e     = (m_pos - TQ) / TQ + 1;
                    n_ext = (e < SJW) ? e : SJW;
                end else if (eseg == 3) begin
                    k = (m_pos - ph1_end) / TQ;
                    if (P2 - k <= SJW) begin
                        n_pos = TQ; n_ext = 0; n_short = 0;
                    end else begin
                        n_short = SJW;
                    end
                end
            end
            m_pos = n_pos; m_ext = n_ext; m_short = n_short;
            m_done = n_done; m_sb = n_sb; m_rxp = rx;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Advance at least one clk until the chosen pulse (0 tx, 1 sample) is seen
    task automatic wait_sig(input int which, input int maxc, output int n);
        logic s;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            s = (which == 0) ? tx_pulse : sample_pulse;
        end while (!s && n < maxc);
        if (!s) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s: no pulse within %0d clk", (which == 0) ? "tx" : "sample", maxc);
        end
    endtask

    initial begin
        int n, a, b;

        // Reset with enable low, then enable under reset, then release
        step(3);
        enable = 1'b1;
        step(2);
        check("rst_seg", seg, 0);
        check("rst_tx_gated", tx_pulse, 0);
        rst = 1'b0;
        #1;
        check("first_tx", tx_pulse, 1);

        // Nominal recessive bits
        wait_sig(1, 60, n); check("nom_tx_to_sample", n, 27);
        wait_sig(0, 60, n); check("nom_sample_to_tx", n, 13);
        check("nom_sampled_bit", sampled_bit, 1);
        wait_sig(1, 60, a);
        wait_sig(0, 60, b); check("nom_bit_len", a + b, 40);

        // Hard sync at an arbitrary PROP clk
        hard_sync_en = 1'b1;
        step(6);
        rx = 1'b0;
        wait_sig(1, 60, n); check("hs_edge_to_sample", n, 24);
        step(1);
        check("hs_sampled_bit", sampled_bit, 0);
        rx = 1'b1;
        hard_sync_en = 1'b0;
        wait_sig(0, 60, n); check("hs_sample_to_tx", n, 12);
        wait_sig(1, 60, n);
        wait_sig(0, 60, n);

        // Late edge in PROP, seg_cnt=1: PH1 gains one tq
        step(9);
        rx = 1'b0;
        wait_sig(1, 60, n); check("late_edge_to_sample", n, 22);
        step(1);
        rx = 1'b1;
        wait_sig(0, 60, a); check("late_bit_len", 9 + n + 1 + a, 44);
        wait_sig(1, 60, a);
        wait_sig(0, 60, b); check("after_late_bit_len", a + b, 40);

        // Early edge in PH2, seg_cnt=1: PH2 loses one tq
        step(33);
        rx = 1'b0;
        wait_sig(0, 60, n); check("early_short_bit_len", 33 + n, 36);
        rx = 1'b1;

        // Early edge in PH2, seg_cnt=2: restart at PROP without tx
        wait_sig(1, 60, n); check("post_early_tx_to_sample", n, 27);
        step(10);
        rx = 1'b0;
        wait_sig(1, 60, n); check("jump_edge_to_sample", n, 24);
        step(1);
        check("jump_sampled_bit", sampled_bit, 0);
        rx = 1'b1;
        wait_sig(0, 60, n); check("jump_sample_to_tx", n, 12);
        wait_sig(1, 60, n);
        wait_sig(0, 60, n);

        // Edge in SYNC consumes the resync; the PROP edge after it is ignored
        step(1);
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(6);
        rx = 1'b0;
        wait_sig(1, 60, n); check("double_edge_to_sample", n, 18);
        step(1);
        rx = 1'b1;
        wait_sig(0, 60, n);

        // Reset in the middle of PH1
        step(20);
        check("pre_rst_seg", seg, 2);
        rst = 1'b1;
        step(1);
        check("mid_rst_seg", seg, 0);
        check("mid_rst_tx", tx_pulse, 0);
        check("mid_rst_sample", sample_pulse, 0);
        check("mid_rst_tick", tq_tick, 0);
        check("mid_rst_sampled_bit", sampled_bit, 1);
        rst = 1'b0;
        #1;
        check("post_rst_tx", tx_pulse, 1);
        wait_sig(1, 60, n); check("post_rst_tx_to_sample", n, 27);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Bit-timing controller for the CAN controller. It replaces the fixed-rate baud toggle with a time-quantum (tq) sequencer.
- Each nominal bit is divided into SYNC, PROP, PHASE1 and PHASE2 segments.
- Outputs: a one-clock tx_pulse at bit start and a one-clock sample_pulse at the sample point, plus the sampled bit.
- Applies CAN hard synchronisation and resynchronisation on recessive-to-dominant rx edges. Feeds the bit stream, stuffing and frame logic.

Parameters:
- TQ_DIV, 10'd4, clk cycles per time quantum (20 MHz / 4 = 5 MHz tq).
- PROP_SEG, 4'd3, propagation segment length in tq (1..8).
- PHASE1, 4'd3, phase segment 1 length in tq (1..8).
- PHASE2, 4'd3, phase segment 2 length in tq (1..8; must be >= SJW).
- SJW, 3'd1, resync jump width in tq (1..4).

Ports:
- clk  input  1  system clock (20 MHz).
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run bit timing; low holds the block in its reset state.
- rx  input  1  CAN receive line, already synchronised to clk; 1 = recessive.
- hard_sync_en  input  1  bus idle / awaiting SOF; the next falling edge hard-syncs.
- tq_tick  output  1  one-clk pulse on the last clk of each tq.
- tx_pulse  output  1  one-clk pulse on the first clk of SYNC (transmit point).
- sample_pulse  output  1  one-clk pulse on the last clk of PHASE1.
- sampled_bit  output  1  rx value captured at sample_pulse.
- seg  output  2  current segment: 0 SYNC, 1 PROP, 2 PH1, 3 PH2.

Behaviour:
- Reset and enable=0:
  - presc=0, seg=SYNC, seg_cnt=0, ph1_ext=0, ph2_short=0, resync_done=0, rx_prev=1.
  - tq_tick=0, tx_pulse=0, sample_pulse=0, sampled_bit=1.
  - Reset takes priority over everything; mid-bit reset aborts the bit.
- Prescaler:
  - presc counts 0..TQ_DIV-1 and wraps.
  - tq_tick=1 when presc==TQ_DIV-1.
  - All segment counters advance only on tq_tick.
- Segment FSM, on tq_tick at the end of a segment:
  - SYNC (1 tq) -> PROP.
  - PROP (PROP_SEG tq) -> PH1.
  - PH1 (PHASE1+ph1_ext tq) -> PH2.
  - PH2 (PHASE2-ph2_short tq) -> SYNC.
  - seg_cnt clears on each transition. ph1_ext and ph2_short clear on entering SYNC.
- Nominal timing at defaults:
  - Bit = 10 tq = 40 clk.
  - tx_pulse at offset 0, sample_pulse at offset 27 (both relative to the bit's first clk).
- Edge detection:
  - edge = rx_prev & ~rx, evaluated every clk.
  - rx_prev <= rx every clk.
- Hard sync (edge & hard_sync_en) overrides resync:
  - Next clk: seg=PROP, seg_cnt=0, presc=0, ext/short=0, resync_done=1.
  - No tx_pulse is generated; the edge tq counts as SYNC.
- Resync applies when edge & ~hard_sync_en & ~resync_done & sampled_bit==1, with k = seg_cnt. Every case below sets resync_done=1.
  - In SYNC: no correction.
  - In PROP (late edge): e=k+1, ph1_ext=min(e,SJW).
  - In PH1 (late edge): e=PROP_SEG+k+1, ph1_ext=min(e,SJW).
  - In PH2 (early edge), with r=PHASE2-k:
    - If r<=SJW: next clk seg=PROP, seg_cnt=0, presc=0 (edge tq becomes SYNC); no tx_pulse.
    - Otherwise: ph2_short=SJW.
- resync_done clears on sample_pulse, giving at most one resync per bit.
- sample_pulse and the sampled_bit<=rx capture occur in the same clk.
- Simultaneous edge and tq_tick: the edge action takes priority over the normal tick advance.

Decomposition:
- Package can_timing_pkg: seg encoding constants (SEG_SYNC..SEG_PH2) and default timing constants.
- Sub-module can_tq_prescaler (clk, rst, clear, tq_tick): a BaudGen-style counter with a synchronous clear.
- FSM and sync logic stay in can_bit_timing.

Test Plan:
- Reset, enable=1, rx=1 held: tx_pulse every 40 clk; sample_pulse 27 clk after each tx_pulse; sampled_bit=1; seg sequence 0,1,2,3.
- hard_sync_en=1, rx falls at an arbitrary clk: PROP starts next clk with presc=0; first sample_pulse 24 clk after the edge; sampled_bit=0.
- Late edge: after a recessive sample, rx falls in PROP at seg_cnt=1: PH1 extended 1 tq; that bit lasts 44 clk; the next bit is 40 clk.
- Early edge in PH2 at seg_cnt=1 (r=2>SJW): PH2 shortened to 2 tq; bit lasts 36 clk.
- Early edge in PH2 at seg_cnt=2 (r=1<=SJW): seg=PROP next clk; no tx_pulse; the next sample_pulse is 24 clk after the edge.
- Two falling edges in one bit, plus rst asserted mid-PH1: second edge ignored (resync_done); on reset all outputs return to reset values the next clk.
